// File: rtl/bp_stream_cmd_responder.sv
// bp_stream_cmd_responder
// Memory-side endpoint of the BedRock I/O command network. Accepts one io_cmd
// at a time, serializes it as an NBF packet {opcode, addr, data} onto an
// outbound flit stream (flit 0 = lowest bits), collects the data word for
// reads from the inbound flit stream, then answers with io_resp.
//
// Ports
//   clk_i, reset_n_i                   clock, asynchronous active-low reset
//   io_cmd_header_i/data_i/v_i         BedRock command in
//   io_cmd_yumi_o                      command consumed this cycle
//   io_resp_header_o/data_o/v_o        BedRock response out
//   io_resp_ready_i                    response accepted
//   stream_v_o/data_o, stream_ready_i  outbound NBF flits
//   stream_v_i/data_i, stream_ready_o  inbound read-return flits
//   busy_o                             high whenever not IDLE
//
// Header layout (LSB first): msg_type[3:0], addr, size[2:0], payload.
module bp_stream_cmd_responder #(
  parameter int unsigned paddr_width_p           = 40,
  parameter int unsigned cce_block_width_p       = 512,
  parameter int unsigned bedrock_payload_width_p = 16,
  parameter int unsigned stream_data_width_p     = 32,
  parameter int unsigned nbf_opcode_width_p      = 8,
  parameter int unsigned nbf_addr_width_p        = paddr_width_p,
  parameter int unsigned nbf_data_width_p        = 64,
  localparam int unsigned cce_mem_header_width_lp =
    4 + paddr_width_p + 3 + bedrock_payload_width_p
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,

  input  logic [cce_mem_header_width_lp-1:0] io_cmd_header_i,
  input  logic [cce_block_width_p-1:0]       io_cmd_data_i,
  input  logic                               io_cmd_v_i,
  output logic                               io_cmd_yumi_o,

  output logic [cce_mem_header_width_lp-1:0] io_resp_header_o,
  output logic [cce_block_width_p-1:0]       io_resp_data_o,
  output logic                               io_resp_v_o,
  input  logic                               io_resp_ready_i,

  output logic                               stream_v_o,
  output logic [stream_data_width_p-1:0]     stream_data_o,
  input  logic                               stream_ready_i,

  input  logic                               stream_v_i,
  input  logic [stream_data_width_p-1:0]     stream_data_i,
  output logic                               stream_ready_o,

  output logic                               busy_o
);

  // Header field positions
  localparam int unsigned type_w     = 4;
  localparam int unsigned addr_lsb   = type_w;
  localparam int unsigned size_lsb   = addr_lsb + paddr_width_p;

  // Packet and counter geometry
  localparam int unsigned pkt_w           = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned nbf_num_flits_lp = (pkt_w + stream_data_width_p - 1) / stream_data_width_p;
  localparam int unsigned rd_num_flits_lp  = (nbf_data_width_p + stream_data_width_p - 1) / stream_data_width_p;
  localparam int unsigned pad_w           = nbf_num_flits_lp * stream_data_width_p;
  localparam int unsigned rd_buf_w        = rd_num_flits_lp * stream_data_width_p;
  localparam int unsigned max_flits       = (nbf_num_flits_lp > rd_num_flits_lp) ? nbf_num_flits_lp : rd_num_flits_lp;
  localparam int unsigned cnt_w           = $clog2(max_flits + 1);
  localparam int unsigned lanes           = cce_block_width_p / nbf_data_width_p;

  localparam logic [3:0] e_bedrock_mem_rd    = 4'd0;
  localparam logic [3:0] e_bedrock_mem_uc_rd = 4'd2;

  localparam logic [1:0] st_idle    = 2'd0;
  localparam logic [1:0] st_send    = 2'd1;
  localparam logic [1:0] st_wait_rd = 2'd2;
  localparam logic [1:0] st_resp    = 2'd3;

  logic [1:0]                         state, state_n;
  logic [cnt_w-1:0]                   cnt, cnt_n;
  logic [cce_mem_header_width_lp-1:0] hdr_r;
  logic [nbf_data_width_p-1:0]        data_r;
  logic                               is_rd_r;
  logic [1:0]                         sz_r;
  logic [rd_buf_w-1:0]                rd_buf;

  logic [3:0]                         cmd_type;
  logic [2:0]                         cmd_size;
  logic                               cmd_is_rd;
  logic [1:0]                         cmd_sz;
  logic [pad_w-1:0]                   packet;
  logic [stream_data_width_p-1:0]     flit;
  logic [nbf_data_width_p-1:0]        rd_word;
  logic                               unused_data;

  // Keep bytes below 2^sz, zero the rest
  function automatic logic [nbf_data_width_p-1:0] size_mask(input logic [1:0] sz);
    logic [nbf_data_width_p-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < nbf_data_width_p / 8; i++) begin
      if (i < (32'd1 << sz)) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Command decode; sizes above 8 bytes clamp to the dword code
  assign cmd_type  = io_cmd_header_i[type_w-1:0];
  assign cmd_size  = io_cmd_header_i[size_lsb +: 3];
  assign cmd_is_rd = (cmd_type == e_bedrock_mem_rd) || (cmd_type == e_bedrock_mem_uc_rd);
  assign cmd_sz    = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];

  // Only the low dword of command data is carried
  assign unused_data = ^io_cmd_data_i[cce_block_width_p-1:nbf_data_width_p];

  // NBF packet: opcode bit 4 marks a read, low bits carry the size code
  assign packet = pad_w'({nbf_opcode_width_p'({is_rd_r, 2'b00, sz_r}),
                          hdr_r[addr_lsb +: nbf_addr_width_p],
                          data_r});

  // Current outbound flit
  always_comb begin
    flit = '0;
    for (int unsigned k = 0; k < nbf_num_flits_lp; k++) begin
      if (cnt == cnt_w'(k)) flit = packet[k*stream_data_width_p +: stream_data_width_p];
    end
  end

  assign rd_word = rd_buf[nbf_data_width_p-1:0] & size_mask(sz_r);

  // State and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= st_idle;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, counter and handshake outputs
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    io_cmd_yumi_o    = 1'b0;
    stream_v_o       = 1'b0;
    stream_data_o    = '0;
    stream_ready_o   = 1'b0;
    io_resp_v_o      = 1'b0;
    io_resp_header_o = '0;
    io_resp_data_o   = '0;
    busy_o           = (state != st_idle);
    case (state)
      st_idle: begin
        // reset_n_i in the term keeps yumi low while reset is held
        if (io_cmd_v_i && reset_n_i) begin
          io_cmd_yumi_o = 1'b1;
          cnt_n         = '0;
          state_n       = st_send;
        end
      end
      st_send: begin
        stream_v_o    = 1'b1;
        stream_data_o = flit;
        if (stream_ready_i) begin
          cnt_n = cnt + cnt_w'(1);
          if (cnt == cnt_w'(nbf_num_flits_lp - 1)) begin
            if (is_rd_r) begin
              cnt_n   = '0;
              state_n = st_wait_rd;
            end else begin
              state_n = st_resp;
            end
          end
        end
      end
      st_wait_rd: begin
        stream_ready_o = 1'b1;
        if (stream_v_i) begin
          cnt_n = cnt + cnt_w'(1);
          if (cnt == cnt_w'(rd_num_flits_lp - 1)) state_n = st_resp;
        end
      end
      st_resp: begin
        io_resp_v_o      = 1'b1;
        io_resp_header_o = hdr_r;
        io_resp_data_o   = is_rd_r ? {lanes{rd_word}} : '0;
        if (io_resp_ready_i) state_n = st_idle;
      end
      default: state_n = st_idle;
    endcase
  end

  // Command capture and read-return assembly
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hdr_r   <= '0;
      data_r  <= '0;
      is_rd_r <= 1'b0;
      sz_r    <= 2'd0;
      rd_buf  <= '0;
    end else begin
      if (io_cmd_yumi_o) begin
        hdr_r   <= io_cmd_header_i;
        data_r  <= io_cmd_data_i[nbf_data_width_p-1:0] & size_mask(cmd_sz);
        is_rd_r <= cmd_is_rd;
        sz_r    <= cmd_sz;
      end
      if (state == st_wait_rd && stream_v_i) begin
        for (int unsigned k = 0; k < rd_num_flits_lp; k++) begin
          if (cnt == cnt_w'(k)) rd_buf[k*stream_data_width_p +: stream_data_width_p] <= stream_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_stream_cmd_responder.sv
// Directed bench for bp_stream_cmd_responder: a table of transactions with
// hand-computed flits and response data, plus hand-written sequences for
// backpressure, reset mid-SEND and unsolicited return flits.
module tb_bp_stream_cmd_responder;

  localparam int unsigned HDR_W = 63;
  localparam int unsigned BLK_W = 512;

  logic              clk = 1'b0;
  logic              reset_n_i;
  logic [HDR_W-1:0]  io_cmd_header_i;
  logic [BLK_W-1:0]  io_cmd_data_i;
  logic              io_cmd_v_i;
  logic              io_cmd_yumi_o;
  logic [HDR_W-1:0]  io_resp_header_o;
  logic [BLK_W-1:0]  io_resp_data_o;
  logic              io_resp_v_o;
  logic              io_resp_ready_i;
  logic              stream_v_o;
  logic [31:0]       stream_data_o;
  logic              stream_ready_i;
  logic              stream_v_i;
  logic [31:0]       stream_data_i;
  logic              stream_ready_o;
  logic              busy_o;

  bp_stream_cmd_responder dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n_i),
    .io_cmd_header_i  (io_cmd_header_i),
    .io_cmd_data_i    (io_cmd_data_i),
    .io_cmd_v_i       (io_cmd_v_i),
    .io_cmd_yumi_o    (io_cmd_yumi_o),
    .io_resp_header_o (io_resp_header_o),
    .io_resp_data_o   (io_resp_data_o),
    .io_resp_v_o      (io_resp_v_o),
    .io_resp_ready_i  (io_resp_ready_i),
    .stream_v_o       (stream_v_o),
    .stream_data_o    (stream_data_o),
    .stream_ready_i   (stream_ready_i),
    .stream_v_i       (stream_v_i),
    .stream_data_i    (stream_data_i),
    .stream_ready_o   (stream_ready_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       mtype;
    logic [39:0]      addr;
    logic [2:0]       size;
    logic [63:0]      data;
    logic [3:0][31:0] flits;   // flits[0] goes out first
    logic             is_rd;
    logic [31:0]      ret0;
    logic [31:0]      ret1;
    logic [63:0]      rd_word; // expected per-lane response data for reads
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HDR_W-1:0] mk_hdr(input vec_t v);
    return {16'hA5C3, v.size, v.addr, v.mtype};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present the command and check it is consumed in this cycle
  task automatic issue(input vec_t v, input string tag);
    io_cmd_header_i = mk_hdr(v);
    io_cmd_data_i   = {{56{8'hEE}}, v.data};
    io_cmd_v_i      = 1'b1;
    @(negedge clk);
    chk({tag, " yumi"}, BLK_W'(io_cmd_yumi_o), BLK_W'(1'b1));
    next_cycle();
    io_cmd_v_i = 1'b0;
  endtask

  task automatic send_flits(input vec_t v, input string tag);
    stream_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s flit%0d v", tag, k), BLK_W'(stream_v_o), BLK_W'(1'b1));
      chk($sformatf("%s flit%0d", tag, k), BLK_W'(stream_data_o), BLK_W'(v.flits[k]));
      chk($sformatf("%s flit%0d rdy_o", tag, k), BLK_W'(stream_ready_o), BLK_W'(1'b0));
      next_cycle();
    end
  endtask

  task automatic return_flits(input logic [31:0] lo, input logic [31:0] hi, input string tag);
    stream_v_i    = 1'b1;
    stream_data_i = lo;
    @(negedge clk);
    chk({tag, " ret rdy0"}, BLK_W'(stream_ready_o), BLK_W'(1'b1));
    next_cycle();
    stream_data_i = hi;
    @(negedge clk);
    chk({tag, " ret rdy1"}, BLK_W'(stream_ready_o), BLK_W'(1'b1));
    next_cycle();
    stream_v_i = 1'b0;
  endtask

  task automatic check_resp(input vec_t v, input logic [BLK_W-1:0] exp_data, input string tag);
    io_resp_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, " resp_v"}, BLK_W'(io_resp_v_o), BLK_W'(1'b1));
    chk({tag, " resp_hdr"}, BLK_W'(io_resp_header_o), BLK_W'(mk_hdr(v)));
    chk({tag, " resp_data"}, io_resp_data_o, exp_data);
    next_cycle();
    @(negedge clk);
    chk({tag, " resp_v low"}, BLK_W'(io_resp_v_o), BLK_W'(1'b0));
    chk({tag, " idle"}, BLK_W'(busy_o), BLK_W'(1'b0));
    next_cycle();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    issue(v, tag);
    send_flits(v, tag);
    if (v.is_rd) begin
      return_flits(v.ret0, v.ret1, tag);
      check_resp(v, {8{v.rd_word}}, tag);
    end else begin
      check_resp(v, '0, tag);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " yumi"}, BLK_W'(io_cmd_yumi_o), '0);
    chk({tag, " stream_v"}, BLK_W'(stream_v_o), '0);
    chk({tag, " stream_data"}, BLK_W'(stream_data_o), '0);
    chk({tag, " stream_rdy"}, BLK_W'(stream_ready_o), '0);
    chk({tag, " resp_v"}, BLK_W'(io_resp_v_o), '0);
    chk({tag, " resp_hdr"}, BLK_W'(io_resp_header_o), '0);
    chk({tag, " resp_data"}, io_resp_data_o, '0);
    chk({tag, " busy"}, BLK_W'(busy_o), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [6];
  vec_t v8, vrd;
  int   idx;
  int   c;

  initial begin
    vecs[0] = '{mtype:4'h3, addr:40'h0080001000, size:3'd3, data:64'h1122334455667788,
                flits:{32'h00000300, 32'h80001000, 32'h11223344, 32'h55667788},
                is_rd:1'b0, ret0:32'h0, ret1:32'h0, rd_word:64'h0};
    vecs[1] = '{mtype:4'h3, addr:40'h0000002000, size:3'd2, data:64'hAABBCCDD_DEADBEEF,
                flits:{32'h00000200, 32'h00002000, 32'h00000000, 32'hDEADBEEF},
                is_rd:1'b0, ret0:32'h0, ret1:32'h0, rd_word:64'h0};
    vecs[2] = '{mtype:4'h2, addr:40'h0000100004, size:3'd2, data:64'h0,
                flits:{32'h00001200, 32'h00100004, 32'h00000000, 32'h00000000},
                is_rd:1'b1, ret0:32'hCAFEF00D, ret1:32'h12345678, rd_word:64'h00000000CAFEF00D};
    vecs[3] = '{mtype:4'h1, addr:40'h123456789A, size:3'd0, data:64'h0102030405060708,
                flits:{32'h00000012, 32'h3456789A, 32'h00000000, 32'h00000008},
                is_rd:1'b0, ret0:32'h0, ret1:32'h0, rd_word:64'h0};
    vecs[4] = '{mtype:4'h0, addr:40'h0000000040, size:3'd6, data:64'hFFFF0000_0000FFFF,
                flits:{32'h00001300, 32'h00000040, 32'hFFFF0000, 32'h0000FFFF},
                is_rd:1'b1, ret0:32'h89ABCDEF, ret1:32'h01234567, rd_word:64'h0123456789ABCDEF};
    vecs[5] = '{mtype:4'h2, addr:40'h0000000010, size:3'd1, data:64'h0,
                flits:{32'h00001100, 32'h00000010, 32'h00000000, 32'h00000000},
                is_rd:1'b1, ret0:32'hAAAA5555, ret1:32'h77777777, rd_word:64'h0000000000005555};
    vrd     = '{mtype:4'h2, addr:40'h0000000200, size:3'd3, data:64'h0,
                flits:{32'h00001300, 32'h00000200, 32'h00000000, 32'h00000000},
                is_rd:1'b1, ret0:32'h0BADF00D, ret1:32'h600DCAFE, rd_word:64'h600DCAFE_0BADF00D};
    v8 = vecs[0];

    // Reset with a command already pending: yumi must stay low
    reset_n_i       = 1'b0;
    io_cmd_header_i = mk_hdr(v8);
    io_cmd_data_i   = '1;
    io_cmd_v_i      = 1'b1;
    io_resp_ready_i = 1'b1;
    stream_ready_i  = 1'b1;
    stream_v_i      = 1'b0;
    stream_data_i   = '0;
    repeat (2) next_cycle();
    chk_all_zero("reset");
    io_cmd_v_i = 1'b0;
    reset_n_i  = 1'b1;
    next_cycle();

    // Table of transactions, no backpressure
    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Outbound backpressure 1,0,0,1,... and a 5-cycle response stall;
    // the command stays valid to confirm it is not consumed early.
    io_cmd_header_i = mk_hdr(v8);
    io_cmd_data_i   = {{56{8'hEE}}, v8.data};
    io_cmd_v_i      = 1'b1;
    @(negedge clk);
    chk("bp yumi", BLK_W'(io_cmd_yumi_o), BLK_W'(1'b1));
    next_cycle();
    idx = 0;
    c   = 0;
    while (idx < 4 && c < 30) begin
      stream_ready_i = (c % 3 == 0);
      @(negedge clk);
      chk($sformatf("bp c%0d v", c), BLK_W'(stream_v_o), BLK_W'(1'b1));
      chk($sformatf("bp c%0d flit", c), BLK_W'(stream_data_o), BLK_W'(v8.flits[idx]));
      chk($sformatf("bp c%0d yumi", c), BLK_W'(io_cmd_yumi_o), '0);
      if (stream_ready_i) idx++;
      c++;
      next_cycle();
    end
    chk("bp flits sent", BLK_W'(idx), BLK_W'(4));
    chk("bp cycles", BLK_W'(c), BLK_W'(10));
    stream_ready_i  = 1'b1;
    io_resp_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d resp_v", s), BLK_W'(io_resp_v_o), BLK_W'(1'b1));
      chk($sformatf("bp stall%0d hdr", s), BLK_W'(io_resp_header_o), BLK_W'(mk_hdr(v8)));
      chk($sformatf("bp stall%0d data", s), io_resp_data_o, '0);
      chk($sformatf("bp stall%0d yumi", s), BLK_W'(io_cmd_yumi_o), '0);
      next_cycle();
    end
    io_cmd_v_i      = 1'b0;
    io_resp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp resp final", BLK_W'(io_resp_v_o), BLK_W'(1'b1));
    next_cycle();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("bp after%0d resp_v", s), BLK_W'(io_resp_v_o), '0);
      chk($sformatf("bp after%0d busy", s), BLK_W'(busy_o), '0);
      next_cycle();
    end

    // Reset after flit 1 of an 8B write: everything drops at once
    issue(v8, "rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst flit%0d", k), BLK_W'(stream_data_o), BLK_W'(v8.flits[k]));
      next_cycle();
    end
    reset_n_i = 1'b0;
    #1;
    chk_all_zero("rst mid");
    repeat (2) next_cycle();
    chk_all_zero("rst held");
    reset_n_i = 1'b1;
    next_cycle();
    run_txn(v8, "post_rst");

    // Unsolicited return flits stall until a read consumes them
    stream_v_i    = 1'b1;
    stream_data_i = vrd.ret0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("unsol%0d rdy", s), BLK_W'(stream_ready_o), '0);
      chk($sformatf("unsol%0d busy", s), BLK_W'(busy_o), '0);
      next_cycle();
    end
    issue(vrd, "unsol");
    send_flits(vrd, "unsol");
    return_flits(vrd.ret0, vrd.ret1, "unsol");
    check_resp(vrd, {8{vrd.rd_word}}, "unsol");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
